seg_scan_decoder: RTL and testbench
===================================

# seg_scan_decoder

Receive-side decoder for the multiplexed seven-segment scan bus. It samples the digit-select and segment lines produced by the display scan driver and waits for each pattern to hold steady. Each stable glyph is decoded back to a 4-bit hex value and stored per digit, and a full 8-digit frame is published once every digit has been captured. It sits opposite the scan driver, either in loopback self-check builds or as a bus monitor on the board header.

## Interface
- STABLE_CYC, 16: consecutive identical samples required before a pattern is captured; legal range 2..255.
- clk_in  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- dig_in  input  8  digit select, one-cold active-low; bit i low selects digit i; 8'hFF means blanking.
- seg_in  input  7  segments {g,f,e,d,c,b,a}, active-low (0 = lit).
- digits_out  output  32  decoded frame; digit i is held in bits [4i+3:4i].
- blank_mask  output  8  bit i set when digit i was all-off (7'h7F) in the published frame.
- err_mask  output  8  bit i set when digit i held a non-glyph pattern in the published frame.
- frame_valid  output  1  one-cycle pulse when a new frame is published.
- scan_err  output  1  one-cycle pulse when a stable dig_in pattern is neither one-cold nor 8'hFF.

## Operation
- Input stage: dig_in and seg_in are registered once into samp_dig and samp_seg. All downstream logic works only on these registered samples.
- Stability counter, 8 bits:
  - Cleared to 0 when the current registered sample differs from the previous one.
  - Otherwise increments, saturating at STABLE_CYC-1.
  - An arm flag is set on any change. A capture event fires in the cycle the counter reaches STABLE_CYC-1 while armed, and that event clears arm. This gives exactly one capture per stable run.
- Capture event, by samp_dig value:
  - 8'hFF: no action.
  - Exactly one zero bit at index i: decode samp_seg into the shadow registers for digit i (nibble, blank bit, error bit), then set seen[i]. If seen[i] is already set, the new value overwrites the old one (latest wins).
  - Any other value: pulse scan_err for one cycle; shadow and seen are unchanged.
- Glyph table, active-low gfedcba:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - 7F is blank: nibble 0, blank bit set.
  - Any other pattern is an error: nibble 0, error bit set.
- Publish: in the cycle after seen becomes 8'hFF:
  - Copy the shadow registers into digits_out, blank_mask and err_mask.
  - Pulse frame_valid.
  - Clear seen to 0.
  - Outputs hold their values between publishes.
- Reset, mid-operation included: all outputs go to 0. Internally, seen=0, counter=0, arm=1, shadow=0, samp_dig=8'hFF, samp_seg=7'h7F. A partial frame in progress is discarded.

## Timing
- Latency from an input change to the capture event: STABLE_CYC+1 cycles (1 register stage plus the stable run). With the default, a change at edge n captures at edge n+17.
- Publish happens 1 cycle after the capture that completes the set, so frame_valid is asserted 1 cycle after that capture edge. digits_out, blank_mask and err_mask change in the same cycle frame_valid is high.
- scan_err is asserted in the capture-event cycle, with no added delay.
- A pattern held for fewer than STABLE_CYC samples is ignored. Glitches restart the count.
- A pattern held indefinitely produces exactly one capture.
- A capture and a publish can coincide when the first digit of the next frame is captured in the publish cycle. In that case the new capture sets its seen bit after the clear, so it is not lost.
- The counter saturates and never wraps, even on very long holds.

## Test plan
- Full frame: scan digits 0..7 showing glyphs 1..8 (79,24,30,19,12,02,78,00), 20 cycles each -> one frame_valid; digits_out=32'h87654321, blank_mask=0, err_mask=0.
- Glitch rejection: hold dig_in=8'hFE with seg_in=7'h40 for 10 cycles, then switch to seg_in=7'h08 and hold it → only A captured for digit 0. Full frame with remaining digits as 0 (7'h40) → digits_out=32'h0000000A.
- Blank/error: digit 3 shows 7'h7F and digit 5 shows 7'h55, others 0 → blank_mask=8'h08, err_mask=8'h20, nibbles 3 and 5 are 0.
- Illegal select: dig_in=8'hFC held 20 cycles → scan_err is a single pulse at sample 16 of the run; no seen bit set; no frame_valid.
- Out-of-order and repeated scan: order 7,6,…,0, with digit 2 shown twice (3 then C) → one frame_valid; nibble 2 = C.
- Reset mid-frame: capture digits 0..3, assert rst for 1 cycle, then scan 0..7 → only one frame_valid, after all 8 post-reset captures; all outputs read 0 during and immediately after reset.

Source files
------------

// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: scan bus inputs and decoded frame outputs of the scan decoder
interface seg_scan_decoder_if;
  logic [7:0]  dig_in;
  logic [6:0]  seg_in;
  logic [31:0] digits_out;
  logic [7:0]  blank_mask;
  logic [7:0]  err_mask;
  logic        frame_valid;
  logic        scan_err;
  modport master (output dig_in, seg_in, input digits_out, blank_mask, err_mask, frame_valid, scan_err);
  modport slave  (input dig_in, seg_in, output digits_out, blank_mask, err_mask, frame_valid, scan_err);
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: debounces the seven-segment scan bus, decodes glyphs per digit and publishes 8-digit frames
module seg_scan_decoder #(
  parameter int STABLE_CYC = 16
) (
  input logic clk_in,
  input logic rst,
  seg_scan_decoder_if.slave bus
);
  localparam logic [7:0] LAST = 8'(STABLE_CYC - 1);
  logic [7:0]  samp_dig_q, prev_dig_q;
  logic [6:0]  samp_seg_q, prev_seg_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        arm_q, arm_d;
  logic        change, cap, one_cold, publish;
  logic [7:0]  hit;
  logic [5:0]  dec;
  logic [7:0]  seen_q, seen_d;
  logic [31:0] shd_nib_q, dout_q;
  logic [7:0]  shd_blank_q, shd_err_q, blank_q, err_q;
  logic        fv_q;
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 6'h00;
      7'h79: decode = 6'h01;
      7'h24: decode = 6'h02;
      7'h30: decode = 6'h03;
      7'h19: decode = 6'h04;
      7'h12: decode = 6'h05;
      7'h02: decode = 6'h06;
      7'h78: decode = 6'h07;
      7'h00: decode = 6'h08;
      7'h10: decode = 6'h09;
      7'h08: decode = 6'h0A;
      7'h03: decode = 6'h0B;
      7'h46: decode = 6'h0C;
      7'h21: decode = 6'h0D;
      7'h06: decode = 6'h0E;
      7'h0E: decode = 6'h0F;
      7'h7F: decode = 6'h10;
      default: decode = 6'h20;
    endcase
  endfunction
  // The run that just completed is held in prev_*, even if samp_* changed in the capture cycle
  always_comb begin
    change   = {samp_dig_q, samp_seg_q} != {prev_dig_q, prev_seg_q};
    cnt_d    = change ? 8'd0 : (cnt_q == LAST ? cnt_q : cnt_q + 8'd1);
    cap      = arm_q && (cnt_q == LAST);
    arm_d    = change | (arm_q & ~cap);
    one_cold = $countones(~prev_dig_q) == 1;
    hit      = (cap && one_cold) ? ~prev_dig_q : 8'h00;
    dec      = decode(prev_seg_q);
    publish  = seen_q == 8'hFF;
    seen_d   = (publish ? 8'h00 : seen_q) | hit;
  end
  assign bus.scan_err    = cap && !one_cold && (prev_dig_q != 8'hFF);
  assign bus.digits_out  = dout_q;
  assign bus.blank_mask  = blank_q;
  assign bus.err_mask    = err_q;
  assign bus.frame_valid = fv_q;
  // Input sampling, stability tracking, per-digit shadow capture and frame publish
  always_ff @(posedge clk_in) begin
    if (rst) begin
      samp_dig_q  <= 8'hFF;
      samp_seg_q  <= 7'h7F;
      prev_dig_q  <= 8'hFF;
      prev_seg_q  <= 7'h7F;
      cnt_q       <= 8'd0;
      arm_q       <= 1'b1;
      seen_q      <= 8'h00;
      shd_nib_q   <= 32'h0;
      shd_blank_q <= 8'h00;
      shd_err_q   <= 8'h00;
      dout_q      <= 32'h0;
      blank_q     <= 8'h00;
      err_q       <= 8'h00;
      fv_q        <= 1'b0;
    end else begin
      samp_dig_q <= bus.dig_in;
      samp_seg_q <= bus.seg_in;
      prev_dig_q <= samp_dig_q;
      prev_seg_q <= samp_seg_q;
      cnt_q      <= cnt_d;
      arm_q      <= arm_d;
      seen_q     <= seen_d;
      fv_q       <= publish;
      for (int i = 0; i < 8; i++) begin
        if (hit[i]) begin
          shd_nib_q[4*i +: 4] <= dec[3:0];
          shd_blank_q[i]      <= dec[4];
          shd_err_q[i]        <= dec[5];
        end
      end
      if (publish) begin
        dout_q  <= shd_nib_q;
        blank_q <= shd_blank_q;
        err_q   <= shd_err_q;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scan sequences with a frame scoreboard for seg_scan_decoder
module tb_seg_scan_decoder;
  typedef struct {
    logic [31:0] d;
    logic [7:0]  b;
    logic [7:0]  e;
  } frame_t;
  logic clk_in = 1'b0;
  logic rst = 1'b1;
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int compared = 0, mismatched = 0, frames = 0, serr = 0, cyc = 0, serr_cyc = 0;
  frame_t q[$];
  seg_scan_decoder_if bus();
  seg_scan_decoder #(.STABLE_CYC(16)) dut (.clk_in(clk_in), .rst(rst), .bus(bus));
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic [7:0] d, input logic [6:0] s, input int n);
    @(negedge clk_in);
    bus.dig_in = d;
    bus.seg_in = s;
    repeat (n - 1) @(negedge clk_in);
  endtask
  task automatic show(input int idx, input logic [6:0] s);
    drive(~(8'h01 << idx), s, 20);
  endtask
  task automatic push(input logic [31:0] d, input logic [7:0] b, input logic [7:0] e);
    frame_t f;
    f.d = d;
    f.b = b;
    f.e = e;
    q.push_back(f);
  endtask
  task automatic drain(input string tag, input int exp_frames);
    drive(8'hFF, 7'h7F, 1);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk_in);
    chk({tag, "_drained"}, 32'(q.size()), 32'd0);
    chk({tag, "_frames"}, 32'(frames), 32'(exp_frames));
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_digits"}, bus.digits_out, 32'h0);
    chk({tag, "_blank"}, 32'(bus.blank_mask), 32'h0);
    chk({tag, "_err"}, 32'(bus.err_mask), 32'h0);
    chk({tag, "_fv"}, 32'(bus.frame_valid), 32'h0);
    chk({tag, "_serr"}, 32'(bus.scan_err), 32'h0);
  endtask
  always @(negedge clk_in) begin
    frame_t f;
    if (bus.scan_err) begin
      serr++;
      serr_cyc = cyc;
    end
    if (bus.frame_valid) begin
      frames++;
      chk("frame_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        f = q.pop_front();
        chk("digits_out", bus.digits_out, f.d);
        chk("blank_mask", 32'(bus.blank_mask), 32'(f.b));
        chk("err_mask", 32'(bus.err_mask), 32'(f.e));
      end
    end
  end
  initial begin
    int t0, s0;
    bus.dig_in = 8'hFF;
    bus.seg_in = 7'h7F;
    repeat (3) @(negedge clk_in);
    chk_zero("reset");
    rst = 1'b0;
    drive(8'hFF, 7'h7F, 20);
    chk_zero("idle");
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(32'h87654321, 8'h00, 8'h00);
      show(i, glyph[i + 1]);
    end
    drain("full", 1);
    drive(8'hFE, 7'h40, 10);
    drive(8'hFE, 7'h08, 20);
    for (int i = 1; i < 8; i++) begin
      if (i == 7) push(32'h0000000A, 8'h00, 8'h00);
      show(i, glyph[0]);
    end
    drain("glitch", 2);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(32'h0, 8'h08, 8'h20);
      show(i, i == 3 ? 7'h7F : (i == 5 ? 7'h55 : glyph[0]));
    end
    drain("blank_err", 3);
    s0 = serr;
    @(negedge clk_in);
    bus.dig_in = 8'hFC;
    bus.seg_in = glyph[5];
    t0 = cyc;
    repeat (19) @(negedge clk_in);
    drive(8'hFF, 7'h7F, 5);
    chk("illegal_pulses", 32'(serr - s0), 32'd1);
    chk("illegal_latency", 32'(serr_cyc - t0), 32'd17);
    for (int i = 1; i < 8; i++) show(i, glyph[5]);
    drive(8'hFF, 7'h7F, 20);
    chk("illegal_no_frame", 32'(frames), 32'd3);
    push(32'h55555555, 8'h00, 8'h00);
    show(0, glyph[5]);
    drain("illegal_then_full", 4);
    for (int i = 7; i >= 0; i--) begin
      if (i == 2) begin
        show(2, glyph[3]);
        chk("ooo_no_early_frame", 32'(frames), 32'd4);
      end else if (i == 1) begin
        show(1, glyph[1]);
        show(2, glyph[12]);
      end else begin
        if (i == 0) push(32'h76543C10, 8'h00, 8'h00);
        show(i, glyph[i]);
      end
    end
    drain("ooo", 5);
    for (int i = 0; i < 4; i++) show(i, glyph[15]);
    @(negedge clk_in);
    rst = 1'b1;
    bus.dig_in = 8'hFF;
    bus.seg_in = 7'h7F;
    @(negedge clk_in);
    chk_zero("midrst_during");
    rst = 1'b0;
    @(negedge clk_in);
    chk_zero("midrst_after");
    for (int i = 0; i < 8; i++) begin
      if (i == 7) push(32'hFEDCBA98, 8'h00, 8'h00);
      show(i, glyph[i + 8]);
      if (i == 6) chk("midrst_no_early_frame", 32'(frames), 32'd5);
    end
    drain("midrst", 6);
    chk("no_stray_scan_err", 32'(serr), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
